// File: rtl/fp_mul_param.sv
// Parametrised multi-cycle floating-point multiplier (IDLE/MUL/NORM/ROUND/DONE) with valid/ready on both sides.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ovf,
  output logic                   unf,
  output logic                   inv,
  output logic [2:0]             dbg_state
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_MIN = XW'(0);

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

  state_t state, state_n;

  logic [W-1:0]           a_q, b_q;
  logic                   sign_q;
  logic signed [XW-1:0]   exp_q;
  logic [PW-1:0]          prod_q;
  logic                   nan_q, inf_q, zero_q;
  logic [MAN_W-1:0]       frac_q;
  logic                   g_q, s_q;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, so they never overlap.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = MUL;
      MUL:     state_n = NORM;
      NORM:    state_n = ROUND;
      ROUND:   state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand classification; exponent zero is treated as zero (denormals-are-zero).
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  logic [PW-1:0] norm;
  assign norm = prod_q[PW-1] ? prod_q : {prod_q[PW-2:0], 1'b0};

  logic inc;
`ifdef FP_MUL_RNE_EN
  assign inc = g_q & (s_q | frac_q[0]);
`else
  logic unused_round_bits;
  assign inc               = 1'b0;
  assign unused_round_bits = g_q ^ s_q;
`endif

  logic                 carry;
  logic [MAN_W-1:0]     frac_r;
  logic signed [XW-1:0] exp_r;
  logic [W-1:0]         res_n;
  logic                 ovf_n, unf_n, inv_n;

  always_comb begin
    {carry, frac_r} = {1'b0, frac_q} + {{MAN_W{1'b0}}, inc};
    exp_r = exp_q + $signed({{(XW-1){1'b0}}, carry});
    res_n = {sign_q, exp_r[EXP_W-1:0], frac_r};
    ovf_n = 1'b0;
    unf_n = 1'b0;
    inv_n = 1'b0;
    // Special operands take priority over the arithmetic range check.
    if (nan_q) begin
      res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      inv_n = 1'b1;
    end else if (inf_q) begin
      res_n = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_q) begin
      res_n = {sign_q, {(W-1){1'b0}}};
    end else if (exp_r >= EXP_MAX) begin
      res_n = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
    end else if (exp_r <= EXP_MIN) begin
      res_n = {sign_q, {(W-1){1'b0}}};
      unf_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
      exp_q  <= '0;
      prod_q <= '0;
      nan_q  <= 1'b0;
      inf_q  <= 1'b0;
      zero_q <= 1'b0;
      frac_q <= '0;
      g_q    <= 1'b0;
      s_q    <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      inv    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          ovf <= 1'b0;
          unf <= 1'b0;
          inv <= 1'b0;
        end
        MUL: begin
          sign_q <= a_q[W-1] ^ b_q[W-1];
          exp_q  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
          prod_q <= PW'({1'b1, fa}) * PW'({1'b1, fb});
          nan_q  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
          inf_q  <= a_inf | b_inf;
          zero_q <= a_zero | b_zero;
        end
        NORM: begin
          frac_q <= norm[PW-2:MAN_W+1];
          g_q    <= norm[MAN_W];
          s_q    <= |norm[MAN_W-1:0];
          exp_q  <= exp_q + $signed({{(XW-1){1'b0}}, prod_q[PW-1]});
        end
        ROUND: begin
          result <= res_n;
          ovf    <= ovf_n;
          unf    <= unf_n;
          inv    <= inv_n;
        end
        default: ;
      endcase
    end
  end

endmodule
